// File: rtl/step_pulse_gen_if.sv
// Step request / step enable bundle between a button or slow level source and step_pulse_gen.
interface step_pulse_gen_if;
  localparam int unsigned STEP_CNT_W = 16;

  logic                  btn_in;
  logic                  run_mode;
  logic                  step_out;
  logic [STEP_CNT_W-1:0] step_count;
  logic                  btn_state;

  modport master (
    output btn_in,
    output run_mode,
    input  step_out,
    input  step_count,
    input  btn_state
  );

  modport slave (
    input  btn_in,
    input  run_mode,
    output step_out,
    output step_count,
    output btn_state
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Debounced single-step / free-running step enable generator for the multicycle CPU.
// Optional hold-to-repeat stepping is built when STEP_AUTOREPEAT_EN is defined.
module step_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RUN_PERIOD      = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 12500000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             CLK_in,
  input  logic             RST,
  step_pulse_gen_if.slave  bus
);

  localparam int unsigned STEP_CNT_W = 16;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2 || RUN_PERIOD < 2 || REPEAT_PERIOD < 2) begin : g_param_chk
    $error("step_pulse_gen: DEBOUNCE_CYCLES, RUN_PERIOD and REPEAT_PERIOD must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PRESS_WAIT = 2'd1,
    S_HELD       = 2'd2,
    S_REL_WAIT   = 2'd3
  } state_t;

  logic                  sync1_q;
  logic                  sync2_q;
  state_t                state_q;
  state_t                state_nxt;
  logic [CNT_W-1:0]      db_cnt_q;
  logic [CNT_W-1:0]      db_cnt_nxt;
  logic [CNT_W-1:0]      run_cnt_q;
  logic [CNT_W-1:0]      run_cnt_nxt;
  logic                  press_accept_c;
  logic                  run_pulse_c;
  logic                  rep_pulse_c;
  logic                  step_nxt;
  logic                  btn_state_nxt;
  logic                  step_q;
  logic [STEP_CNT_W-1:0] step_count_q;
  logic                  btn_state_q;

  // Two-flop synchronizer for the asynchronous request
  always_ff @(posedge CLK_in) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM state register
  always_ff @(posedge CLK_in) begin
    if (RST) begin
      state_q  <= S_IDLE;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_nxt;
      db_cnt_q <= db_cnt_nxt;
    end
  end

  // Debounce FSM next state; a level change must persist DEBOUNCE_CYCLES more edges
  always_comb begin
    state_nxt      = state_q;
    db_cnt_nxt     = db_cnt_q;
    press_accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sync2_q) begin
          state_nxt  = S_PRESS_WAIT;
          db_cnt_nxt = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_nxt = S_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_nxt      = S_HELD;
          press_accept_c = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt_q + CNT_ONE;
        end
      end
      S_HELD: begin
        if (!sync2_q) begin
          state_nxt  = S_REL_WAIT;
          db_cnt_nxt = '0;
        end
      end
      S_REL_WAIT: begin
        if (sync2_q) begin
          state_nxt = S_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          db_cnt_nxt = db_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        db_cnt_nxt = '0;
      end
    endcase
  end

  // Free-running period counter, parked at zero outside run mode
  always_comb begin
    run_pulse_c = 1'b0;
    run_cnt_nxt = '0;
    if (bus.run_mode) begin
      if (run_cnt_q == RUN_LAST) begin
        run_pulse_c = 1'b1;
      end else begin
        run_cnt_nxt = run_cnt_q + CNT_ONE;
      end
    end
  end

`ifdef STEP_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_cnt_q;
  logic [CNT_W-1:0] rep_cnt_nxt;

  // Repeat timer runs only while held in single-step mode; cleared everywhere else
  always_comb begin
    rep_pulse_c = 1'b0;
    rep_cnt_nxt = '0;
    if (state_q == S_HELD && !bus.run_mode) begin
      if (rep_cnt_q == REP_LAST) begin
        rep_pulse_c = 1'b1;
      end else begin
        rep_cnt_nxt = rep_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK_in) begin
    if (RST) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_nxt;
    end
  end
`else
  assign rep_pulse_c = 1'b0;
`endif

  // Output decode; sources are mutually exclusive through run_mode and FSM state
  always_comb begin
    step_nxt      = run_pulse_c | (press_accept_c & ~bus.run_mode) | rep_pulse_c;
    btn_state_nxt = (state_nxt == S_HELD) || (state_nxt == S_REL_WAIT);
  end

  always_ff @(posedge CLK_in) begin
    if (RST) begin
      run_cnt_q    <= '0;
      step_q       <= 1'b0;
      step_count_q <= '0;
      btn_state_q  <= 1'b0;
    end else begin
      run_cnt_q   <= run_cnt_nxt;
      step_q      <= step_nxt;
      btn_state_q <= btn_state_nxt;
      if (step_nxt) begin
        step_count_q <= step_count_q + STEP_CNT_W'(1);
      end
    end
  end

  assign bus.step_out   = step_q;
  assign bus.step_count = step_count_q;
  assign bus.btn_state  = btn_state_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen: directed scenarios plus randomized traffic against a run-length model.
module tb_step_pulse_gen;

  localparam int unsigned DB  = 4;
  localparam int unsigned RP  = 5;
  localparam int unsigned REP = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   cmp_en;

  step_pulse_gen_if bus ();

  step_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .RUN_PERIOD      (RP),
    .REPEAT_PERIOD   (REP),
    .CNT_W           (32)
  ) dut (
    .CLK_in (clk),
    .RST    (rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a debounced level flips once the synchronized input has
  // disagreed with it on DB+1 consecutive edges.
  bit          h1, h2;
  bit          lvl;
  int          runlen;
  int          run_n;
  bit          exp_step;
  logic [15:0] exp_cnt;
`ifdef STEP_AUTOREPEAT_EN
  int          held_n;
`endif

  always @(posedge clk) begin
    bit p;
    p = 1'b0;
    if (rst) begin
      h1 = 0; h2 = 0; lvl = 0; runlen = 0; run_n = 0;
      exp_step = 0; exp_cnt = 16'd0;
`ifdef STEP_AUTOREPEAT_EN
      held_n = 0;
`endif
    end else begin
      if (bus.run_mode) begin
        run_n++;
        if (run_n % RP == 0) p = 1'b1;
      end else begin
        run_n = 0;
      end
`ifdef STEP_AUTOREPEAT_EN
      if (lvl && runlen == 0 && !bus.run_mode) begin
        held_n++;
        if (held_n % REP == 0) p = 1'b1;
      end else begin
        held_n = 0;
      end
`endif
      if (h2 != lvl) begin
        runlen++;
        if (runlen == DB + 1) begin
          lvl    = !lvl;
          runlen = 0;
          if (lvl && !bus.run_mode) p = 1'b1;
        end
      end else begin
        runlen = 0;
      end
      h2 = h1;
      h1 = bus.btn_in;
      exp_step = p;
      if (p) exp_cnt = exp_cnt + 16'd1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_step_out",   int'(bus.step_out),   int'(exp_step));
      check("cyc_step_count", int'(bus.step_count), int'(exp_cnt));
      check("cyc_btn_state",  int'(bus.btn_state),  int'(lvl));
    end
  end

  initial begin
    int cnt;
    int want_rep;
    int len;
    bit pat [8];
    n_checks = 0;
    n_fail   = 0;
    cmp_en   = 0;
    rst = 1'b1;
    bus.btn_in   = 1'b0;
    bus.run_mode = 1'b0;
    pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    cyc(1);
    cmp_en = 1;
    cyc(2);
    check("rst_step_out",   int'(bus.step_out),   0);
    check("rst_step_count", int'(bus.step_count), 0);
    check("rst_btn_state",  int'(bus.btn_state),  0);
    rst = 1'b0;
    cyc(3);

    // Short glitch is rejected
    bus.btn_in = 1'b1; cyc(2);
    bus.btn_in = 1'b0; cyc(10);
    check("glitch_count", int'(bus.step_count), 0);
    check("glitch_state", int'(bus.btn_state),  0);

    // Clean press: pulse exactly DB+2 edges after first capture
    bus.btn_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (i == 6) check("press_pre",  int'(bus.step_out), 0);
      if (i == 7) begin
        check("press_pulse", int'(bus.step_out),   1);
        check("press_count", int'(bus.step_count), 1);
        check("press_state", int'(bus.btn_state),  1);
        check("model_press_count", int'(exp_cnt), 1);
      end
      if (i == 8) check("press_post", int'(bus.step_out), 0);
    end

    // Bouncy release, then stable low
    for (int j = 0; j < 8; j++) begin
      bus.btn_in = pat[j];
      cyc(1);
    end
    check("bounce_state", int'(bus.btn_state), 1);
    bus.btn_in = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cyc(1);
      if (i == 6) check("release_pre",  int'(bus.btn_state), 1);
      if (i == 7) check("release_done", int'(bus.btn_state), 0);
    end
    check("release_count", int'(bus.step_count), 1);

    // Run mode with the button pressed meanwhile
    bus.run_mode = 1'b1;
    bus.btn_in   = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (bus.step_out) cnt++;
      if (i == 4) check("run_pre",   int'(bus.step_out), 0);
      if (i == 5) check("run_first", int'(bus.step_out), 1);
    end
    check("run_pulses", cnt, 4);
    check("run_count",  int'(bus.step_count), 5);
    check("model_run_count", int'(exp_cnt), 5);
    bus.run_mode = 1'b0;
    bus.btn_in   = 1'b0;
    cyc(15);

    // Long hold in single-step mode
`ifdef STEP_AUTOREPEAT_EN
    want_rep = 4;
`else
    want_rep = 1;
`endif
    bus.btn_in = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 45; i++) begin
      cyc(1);
      if (bus.step_out) cnt++;
      if (i == 35) bus.btn_in = 1'b0;
    end
    check("hold_pulses", cnt, want_rep);
    check("hold_count",  int'(bus.step_count), 5 + want_rep);
    cyc(10);

    // Reset while held forces a full re-debounce and a fresh pulse
    bus.btn_in = 1'b1;
    cyc(10);
    rst = 1'b1;
    cyc(1);
    check("mrst_step_out",   int'(bus.step_out),   0);
    check("mrst_step_count", int'(bus.step_count), 0);
    check("mrst_btn_state",  int'(bus.btn_state),  0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (i == 6) check("repress_pre", int'(bus.step_out), 0);
      if (i == 7) begin
        check("repress_pulse", int'(bus.step_out),   1);
        check("repress_count", int'(bus.step_count), 1);
      end
      if (i == 8) check("repress_post", int'(bus.step_out), 0);
    end
    bus.btn_in = 1'b0;
    cyc(12);

    // Randomized traffic checked cycle by cycle
    for (int s = 0; s < 600; s++) begin
      bus.btn_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.run_mode = ~bus.run_mode;
      rst = ($urandom_range(0, 63) == 0);
      len = int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) begin
        cyc(1);
        rst = 1'b0;
      end
    end
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
